// File: rtl/md_arbiter_pkg.sv
// md_pkg: opcodes, FSM states and latency constants shared by the HI/LO arbiter slice.
package md_pkg;

  localparam logic [3:0] MD_OP_MULT  = 4'd0;
  localparam logic [3:0] MD_OP_MULTU = 4'd1;
  localparam logic [3:0] MD_OP_DIV   = 4'd2;
  localparam logic [3:0] MD_OP_DIVU  = 4'd3;
  localparam logic [3:0] MD_OP_MTHI  = 4'd4;
  localparam logic [3:0] MD_OP_MTLO  = 4'd5;
  localparam logic [3:0] MD_OP_MFHI  = 4'd6;
  localparam logic [3:0] MD_OP_MFLO  = 4'd7;
  localparam logic [3:0] MD_OP_IDLE  = 4'hF;

  localparam int MD_LAT_MT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } md_state_e;

  // Only MULT..MTLO touch the datapath; reads and illegal codes go out as the idle opcode.
  function automatic logic [3:0] md_dp_op(input logic [3:0] op);
    return (op <= MD_OP_MTLO) ? op : MD_OP_IDLE;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_mult(input logic [3:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

endpackage

// File: rtl/md_arbiter_if.sv
// md_arbiter_if: requester, response and datapath signals of the HI/LO arbiter; slave = arbiter side.
interface md_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_err;

  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp0_ready, resp1_ready,
    input  md_hi, md_lo,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_hi, resp_lo, resp_err,
    output md_start, md_op, md_a, md_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp0_ready, resp1_ready,
    output md_hi, md_lo,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_hi, resp_lo, resp_err,
    input  md_start, md_op, md_a, md_b
  );

endinterface

// File: rtl/md_arbiter_rr_pick.sv
// md_rr_pick: two-way round-robin selector; combinational, rr names the winner only when both are valid.
module md_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic rr,
  output logic gnt_vld,
  output logic gnt_id
);

  assign gnt_vld = valid0 | valid1;
  assign gnt_id  = (valid0 & valid1) ? rr : valid1;

endmodule

// File: rtl/md_arbiter.sv
// md_arbiter: round-robin sequencer for the shared HI/LO mul/div unit; response at grant+LAT, held until resp_ready.
// Requests see ready=0 while an op is in flight. Optional MD_ARB_DIVZERO_EN traps DIV/DIVU by zero with resp_err.
module md_arbiter
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 5
) (
  input logic         clk,
  input logic         reset,
  md_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LAT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAT_MT   = CNT_W'(MD_LAT_MT);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rr, rr_nxt;
  logic             owner, owner_nxt;

  logic             gnt_vld, gnt_id;
  logic [3:0]       win_op;
  logic [31:0]      win_a, win_b;
  logic [CNT_W-1:0] win_lat;
  logic             win_dz;
  logic             resp_rdy;

  md_rr_pick u_pick (
    .valid0  (bus.req0_valid),
    .valid1  (bus.req1_valid),
    .rr      (rr),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign win_op   = gnt_id ? bus.req1_op : bus.req0_op;
  assign win_a    = gnt_id ? bus.req1_a  : bus.req0_a;
  assign win_b    = gnt_id ? bus.req1_b  : bus.req0_b;
  assign resp_rdy = owner ? bus.resp1_ready : bus.resp0_ready;

`ifdef MD_ARB_DIVZERO_EN
  logic err, err_nxt;
  assign win_dz = md_is_div(win_op) && (win_b == '0);
`else
  assign win_dz = 1'b0;
`endif

  // A trapped divide never reaches the datapath, so it answers like an MT/MF op.
  always_comb begin
    win_lat = LAT_MT;
    if (md_is_mult(win_op))
      win_lat = LAT_MULT;
    else if (md_is_div(win_op) && !win_dz)
      win_lat = LAT_DIV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rr    <= 1'b0;
      owner <= 1'b0;
`ifdef MD_ARB_DIVZERO_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rr    <= rr_nxt;
      owner <= owner_nxt;
`ifdef MD_ARB_DIVZERO_EN
      err   <= err_nxt;
`endif
    end
  end

  // All handshake and datapath outputs are gated by reset so nothing is granted or issued during it.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rr_nxt          = rr;
    owner_nxt       = owner;
`ifdef MD_ARB_DIVZERO_EN
    err_nxt         = err;
`endif
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    bus.md_start    = 1'b0;
    bus.md_op       = MD_OP_IDLE;
    bus.md_a        = '0;
    bus.md_b        = '0;

    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            bus.req0_ready = ~gnt_id;
            bus.req1_ready = gnt_id;
            owner_nxt      = gnt_id;
`ifdef MD_ARB_DIVZERO_EN
            err_nxt        = win_dz;
`endif
            if (!win_dz) begin
              bus.md_start = 1'b1;
              bus.md_op    = md_dp_op(win_op);
              bus.md_a     = win_a;
              bus.md_b     = win_b;
            end
            if (win_lat <= LAT_MT) begin
              state_nxt = ST_RESP;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_RUN;
              cnt_nxt   = win_lat - LAT_MT;
            end
          end
        end

        ST_RUN: begin
          cnt_nxt = cnt - LAT_MT;
          if (cnt <= LAT_MT)
            state_nxt = ST_RESP;
        end

        ST_RESP: begin
          bus.resp0_valid = ~owner;
          bus.resp1_valid = owner;
          if (resp_rdy) begin
            state_nxt = ST_IDLE;
            rr_nxt    = ~owner;
`ifdef MD_ARB_DIVZERO_EN
            err_nxt   = 1'b0;
`endif
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.resp_hi = bus.md_hi;
  assign bus.resp_lo = bus.md_lo;

`ifdef MD_ARB_DIVZERO_EN
  assign bus.resp_err = err && (state == ST_RESP) && !reset;
`else
  assign bus.resp_err = 1'b0;
`endif

endmodule

// File: doc/md_arbiter.md
# md_arbiter

Sequencing controller and two-port arbiter for the shared multiply/divide unit (HI/LO datapath) in the E stage. It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It issues a single-cycle start and opcode to the datapath, models the unit's latency with its own countdown, and returns the resulting HI/LO to the owning requester over a response handshake.

## Interface
- `MULT_CYCLES`, default 5: response latency for MULT/MULTU.
- `DIV_CYCLES`, default 10: response latency for DIV/DIVU.
- `CNT_W`, default 5: countdown width; must hold `DIV_CYCLES`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `reqN_valid`  in  1  request N valid (N = 0, 1).
- `reqN_ready`  out  1  request N accepted this cycle.
- `reqN_op`  in  4  opcode: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
- `reqN_a`, `reqN_b`  in  32  operands; MT* uses `a`; MF* ignores both.
- `respN_valid`  out  1  response N valid.
- `respN_ready`  in  1  requester N accepts response.
- `resp_hi`, `resp_lo`  out  32  HI/LO snapshot, shared by both response ports.
- `resp_err`  out  1  divide-by-zero flag (see Configuration).
- `md_start`  out  1  one-cycle start to the datapath.
- `md_op`  out  4  datapath opcode; 4'hF (idle) whenever `md_start`=0.
- `md_a`, `md_b`  out  32  datapath operands; 0 whenever `md_start`=0.
- `md_hi`, `md_lo`  in  32  registered HI/LO from the datapath.

## Operation
- FSM states are IDLE, RUN and RESP.
- **IDLE, grant:** when any `reqN_valid`=1, grant one requester.
  - If both are valid, the requester selected by the round-robin pointer `rr` wins.
  - The winner's `reqN_ready`=1 combinationally in the same cycle.
  - `md_start`=1, and `md_op`, `md_a`, `md_b` carry the winner's values.
  - The owner ID and latency LAT are latched: MULT_CYCLES for 0/1, DIV_CYCLES for 2/3, 1 for 4–7.
  - The FSM moves to RUN with the countdown set to LAT−1, or to RESP directly if LAT=1.
- **MF\* ops:** MFHI/MFLO drive `md_op`=4'hF with `md_start`=1. They do not modify HI/LO and exist only to obtain an ordered read.
- **RUN:** decrement the countdown each cycle; move to RESP when it reaches 0.
- **RESP:**
  - Assert `respN_valid` for the owner only.
  - `resp_hi`/`resp_lo` mirror `md_hi`/`md_lo`.
  - Hold until `respN_ready`=1, then go to IDLE and set `rr` to the other requester.
- **Requester rules:** a requester must hold `valid`, `op`, `a` and `b` stable until `ready`. At most one request is in flight in total.
- **Ready outside IDLE:** `reqN_ready`=0 in RUN and RESP, and for the losing requester in IDLE.
- **Illegal opcodes (8–15):** granted and answered with LAT=1, `md_op`=4'hF, and no datapath effect.

## Timing
- **Grant:** grant at cycle T; datapath HI/LO update at edge T+1.
- **Response:** `respN_valid` is first high in cycle T+LAT. This gives T+5 for MULT, T+10 for DIV and T+1 for MT/MF.
- **Back-to-back:** if the response handshake completes in cycle R, the next grant is possible at R+1. Back-to-back MULT with immediate `resp_ready` therefore grants at T, T+6, T+12.
- **Response hold:** response data remains valid and stable while `resp_ready`=0.
- **Reset values:**
  - FSM state: IDLE.
  - `rr`: 0.
  - Countdown: 0.
  - `reqN_ready` and `respN_valid`: 0.
  - `md_start`: 0, `md_op`: 4'hF, `md_a`/`md_b`: 0.
  - `resp_err`: 0.
- **Reset mid-operation:** the in-flight request and pending response are dropped with no response issued; the datapath is reset by the same signal.
- **Simultaneous release:** a requester deasserting `valid` in the same cycle it would be granted is not a legal stimulus.

## Configuration
- Macro `MD_ARB_DIVZERO_EN`.
- **Defined:** DIV/DIVU with `b`=0 is still granted (`reqN_ready`=1), but `md_start`=0 and `md_op`=4'hF. LAT=1, so the response arrives at T+1 with HI/LO unchanged and `resp_err`=1. `resp_err`=0 for all other responses.
- **Undefined:** `resp_err` is tied to 0, and divide-by-zero is issued to the datapath normally with an undefined result.

## Structure
- **Package `md_pkg`:** opcode constants (including `MD_OP_IDLE`=4'hF), the FSM state enum, and `MD_LAT_MT`=1.
- **Sub-module `md_rr_pick`:** two-way round-robin selector.
  - Inputs: `valid0`, `valid1`, `rr`.
  - Outputs: `gnt_vld`, `gnt_id`.
- **md_arbiter body:** FSM, countdown, owner/latency registers, and the datapath/response muxing.

## Test plan
- **Single MULT:** req0 MULT a=3, b=−2 at T → `md_start` at T; `resp0_valid` at T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Simultaneous requests after reset:** req0 DIVU a=100, b=7 and req1 MULTU a=b=0x10000 → req0 granted first; resp0 at T+10 with HI=2, LO=14. Then req1 is granted at the handshake cycle +1, with HI=1, LO=0.
- **MTHI then MFHI:** MTHI a=0xDEADBEEF then MFHI from req1 → each response at grant+1; MFHI returns HI=0xDEADBEEF.
- **Response backpressure:** hold `resp0_ready`=0 for 4 cycles after a MULT response → `resp_hi`/`resp_lo` stable, no new grant. Release `resp0_ready` → pending req1 granted on the next cycle.
- **Reset mid-DIV:** assert `reset` at T+4 of a DIV → no `respN_valid`, all outputs at reset values, and a fresh request is granted in the first cycle after reset.
- **Divide-by-zero, with `MD_ARB_DIVZERO_EN`:** DIV a=5, b=0 → `md_start`=0, response at T+1 with `resp_err`=1 and HI/LO unchanged. Without the macro → `md_start`=1 and response at T+10.
